// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT magnitude / peak block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_pkg;

    // Default build widths; modules carry their own W / N_BINS parameters.
    localparam int FFT_W      = 16;
    localparam int FFT_N_BINS = 1024;
    localparam int FFT_BW     = $clog2(FFT_N_BINS);

    // Input sample to mag_sq output, in clk cycles.
    localparam int FFT_MAG_LAT = 2;

    // Width of an exact |x|^2 for W-bit signed components: 2W+1 bits.
    function automatic int mag_width(input int w);
        return 2 * w + 1;
    endfunction

    typedef logic [2*FFT_W:0] mag_t;

    typedef struct packed {
        mag_t              mag;
        logic [FFT_BW-1:0] bin;
    } peak_t;

endpackage

// File: rtl/fft_cmag_sq_stage.sv
// Two-stage |re + j*im|^2: stage 1 squares both parts, stage 2 sums them.
// Latency: 2 cycles, valid and sideband delayed alongside the data.
// Backpressure: none; free-running, data/sideband hold while valid is low.
module fft_cmag_sq_stage
    import fft_pkg::*;
#(
    parameter int W  = 16,
    parameter int SW = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [SW-1:0]       in_side,
    input  logic signed [W-1:0] in_real,
    input  logic signed [W-1:0] in_imag,
    output logic                out_valid,
    output logic [SW-1:0]       out_side,
    output logic [2*W:0]        out_mag
);

    // Components are sign-extended first so the products are exact in 2W bits.
    logic signed [2*W-1:0] re_ext;
    logic signed [2*W-1:0] im_ext;
    logic signed [2*W-1:0] re_prod;
    logic signed [2*W-1:0] im_prod;

    assign re_ext  = (2*W)'(in_real);
    assign im_ext  = (2*W)'(in_imag);
    assign re_prod = re_ext * re_ext;
    assign im_prod = im_ext * im_ext;

    // Stage 1 state: each square is non-negative and at most 2^(2W-2).
    logic [2*W-1:0] sq_re;
    logic [2*W-1:0] sq_im;
    logic           s1_valid;
    logic [SW-1:0]  s1_side;

    // Stage 1: register both squares and the sideband on an accepted sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sq_re    <= '0;
            sq_im    <= '0;
            s1_valid <= 1'b0;
            s1_side  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                sq_re   <= re_prod;
                sq_im   <= im_prod;
                s1_side <= in_side;
            end
        end
    end

    // Stage 2: register the widened sum; outputs hold while no sample moves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_side  <= '0;
            out_mag   <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_mag  <= {1'b0, sq_re} + {1'b0, sq_im};
                out_side <= s1_side;
            end
        end
    end

endmodule

// File: rtl/fft_mag_peak.sv
// FFT bin magnitude-squared with bin index, frame overflow and optional per-frame peak.
// Latency: 2 cycles sample-to-mag; peak reported on the final bin's mag_valid cycle.
// Backpressure: none; free-running. Peak tracking built only with FFT_PEAK_DETECT_EN.
module fft_mag_peak
    import fft_pkg::*;
#(
    parameter int  W      = 16,
    parameter int  N_BINS = 1024,
    localparam int BW     = $clog2(N_BINS),
    localparam int MW     = mag_width(W)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                fft_valid,
    input  logic                fft_last,
    input  logic signed [W-1:0] fft_real,
    input  logic signed [W-1:0] fft_imag,
    output logic [2*W:0]        mag_sq,
    output logic                mag_valid,
    output logic                mag_last,
    output logic [BW-1:0]       mag_bin,
    output logic                peak_valid,
    output logic [2*W:0]        peak_mag,
    output logic [BW-1:0]       peak_bin,
    output logic                frame_ovf
);

    // Sideband carried through the squaring pipe: {overflow, last, bin}.
    localparam int SW = BW + 2;

    logic [BW-1:0] bin_cnt;
    logic          cnt_at_max;
    logic          ovf_in;
    logic [SW-1:0] side_in;
    logic [SW-1:0] side_out;
    logic          side_ovf;

    assign cnt_at_max = (bin_cnt == BW'(N_BINS - 1));
    // A full frame with no fft_last is closed by force on its final bin.
    assign ovf_in     = fft_valid & cnt_at_max & ~fft_last;
    assign side_in    = {ovf_in, fft_last, bin_cnt};

    // Bin counter: advance per accepted sample, restart after last or overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_cnt <= '0;
        end else if (fft_valid) begin
            if (fft_last || cnt_at_max) begin
                bin_cnt <= '0;
            end else begin
                bin_cnt <= bin_cnt + BW'(1);
            end
        end
    end

    fft_cmag_sq_stage #(
        .W  (W),
        .SW (SW)
    ) u_sq (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (fft_valid),
        .in_side   (side_in),
        .in_real   (fft_real),
        .in_imag   (fft_imag),
        .out_valid (mag_valid),
        .out_side  (side_out),
        .out_mag   (mag_sq)
    );

    assign mag_bin   = side_out[BW-1:0];
    assign mag_last  = side_out[BW];
    assign side_ovf  = side_out[BW+1];
    // Sideband holds between samples, so the pulse must be gated by mag_valid.
    assign frame_ovf = mag_valid & side_ovf;

`ifdef FFT_PEAK_DETECT_EN
    typedef struct packed {
        logic [MW-1:0] mag;
        logic [BW-1:0] bin;
    } peak_rec_t;

    peak_rec_t run_pk;
    peak_rec_t hold_pk;
    peak_rec_t cand_pk;
    logic      frame_end;

    assign frame_end = mag_valid & (mag_last | side_ovf);

    // Running max including the current bin; bin 0 always opens a new frame,
    // and only a strictly larger value displaces the incumbent (ties keep lower bin).
    always_comb begin
        cand_pk = run_pk;
        if ((mag_bin == '0) || (mag_sq > run_pk.mag)) begin
            cand_pk.mag = mag_sq;
            cand_pk.bin = mag_bin;
        end
    end

    // Track the running peak across the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_pk <= '0;
        end else if (mag_valid) begin
            run_pk <= cand_pk;
        end
    end

    // Latch the reported peak so it holds until the next frame closes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_pk <= '0;
        end else if (frame_end) begin
            hold_pk <= cand_pk;
        end
    end

    // The closing bin's peak is shown in the same cycle as that bin's mag_valid.
    assign peak_valid = frame_end;
    assign peak_mag   = frame_end ? cand_pk.mag : hold_pk.mag;
    assign peak_bin   = frame_end ? cand_pk.bin : hold_pk.bin;
`else
    assign peak_valid = 1'b0;
    assign peak_mag   = '0;
    assign peak_bin   = '0;
`endif

endmodule

// File: tb/tb_fft_mag_peak.sv
// Directed bench for fft_mag_peak with N_BINS = 4 so frame overflow is reachable.
// Peak expectations apply when FFT_PEAK_DETECT_EN is defined, else peak outputs must stay 0.
module tb_fft_mag_peak;
    import fft_pkg::*;

    localparam int W  = 16;
    localparam int NB = 4;
    localparam int BW = 2;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                fft_valid;
    logic                fft_last;
    logic signed [W-1:0] fft_real;
    logic signed [W-1:0] fft_imag;
    logic [2*W:0]        mag_sq;
    logic                mag_valid;
    logic                mag_last;
    logic [BW-1:0]       mag_bin;
    logic                peak_valid;
    logic [2*W:0]        peak_mag;
    logic [BW-1:0]       peak_bin;
    logic                frame_ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    fft_mag_peak #(.W(W), .N_BINS(NB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fft_valid  (fft_valid),
        .fft_last   (fft_last),
        .fft_real   (fft_real),
        .fft_imag   (fft_imag),
        .mag_sq     (mag_sq),
        .mag_valid  (mag_valid),
        .mag_last   (mag_last),
        .mag_bin    (mag_bin),
        .peak_valid (peak_valid),
        .peak_mag   (peak_mag),
        .peak_bin   (peak_bin),
        .frame_ovf  (frame_ovf)
    );

    always #5 clk = ~clk;

    // Drive one input cycle at the falling edge; outputs are stable there too.
    task automatic cyc(input logic v, input logic l, input int re, input int im);
        @(negedge clk);
        fft_valid = v;
        fft_last  = l;
        fft_real  = W'(re);
        fft_imag  = W'(im);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        fft_valid = 1'b0; fft_last = 1'b0; fft_real = '0; fft_imag = '0;
        @(negedge clk); @(negedge clk);
        tests_run++; if (mag_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mag_valid: got %0b want 0", mag_valid); end
        tests_run++; if (mag_sq !== '0) begin tests_failed++; $display("FAIL rst_mag_sq: got %0d want 0", mag_sq); end
        tests_run++; if (mag_bin !== '0 || mag_last !== 1'b0) begin tests_failed++; $display("FAIL rst_bin_last: got %0d/%0b want 0/0", mag_bin, mag_last); end
        tests_run++; if (frame_ovf !== 1'b0 || peak_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_pulses: got ovf %0b pk %0b want 0/0", frame_ovf, peak_valid); end
        tests_run++; if (peak_mag !== '0 || peak_bin !== '0) begin tests_failed++; $display("FAIL rst_peak: got %0d/%0d want 0/0", peak_mag, peak_bin); end
        reset_n = 1'b1;
    endtask

    task automatic test_mag;
        cyc(1, 0, 23964, 29636);
        cyc(1, 1, -7964, -11006);
        tests_run++; if (mag_valid !== 1'b0) begin tests_failed++; $display("FAIL mag_lat_early: got %0b want 0", mag_valid); end
        cyc(0, 0, 0, 0);
        tests_run++; if (mag_valid !== 1'b1) begin tests_failed++; $display("FAIL mag_valid_t2: got %0b want 1", mag_valid); end
        tests_run++; if (mag_sq !== 33'd1452565792) begin tests_failed++; $display("FAIL mag_sq_a: got %0d want 1452565792", mag_sq); end
        tests_run++; if (mag_bin !== 2'd0 || mag_last !== 1'b0) begin tests_failed++; $display("FAIL mag_a_side: got %0d/%0b want 0/0", mag_bin, mag_last); end
        tests_run++; if (peak_valid !== 1'b0) begin tests_failed++; $display("FAIL mag_a_pk: got %0b want 0", peak_valid); end
        cyc(0, 0, 0, 0);
        tests_run++; if (mag_valid !== 1'b1 || mag_sq !== 33'd184557332) begin tests_failed++; $display("FAIL mag_sq_b: got %0b/%0d want 1/184557332", mag_valid, mag_sq); end
        tests_run++; if (mag_bin !== 2'd1 || mag_last !== 1'b1) begin tests_failed++; $display("FAIL mag_b_side: got %0d/%0b want 1/1", mag_bin, mag_last); end
`ifdef FFT_PEAK_DETECT_EN
        tests_run++; if (peak_valid !== 1'b1 || peak_mag !== 33'd1452565792 || peak_bin !== 2'd0) begin tests_failed++; $display("FAIL mag_peak: got %0b/%0d/%0d want 1/1452565792/0", peak_valid, peak_mag, peak_bin); end
`else
        tests_run++; if (peak_valid !== 1'b0 || peak_mag !== '0) begin tests_failed++; $display("FAIL mag_peak_off: got %0b/%0d want 0/0", peak_valid, peak_mag); end
`endif
        cyc(0, 0, 0, 0);
        tests_run++; if (mag_valid !== 1'b0 || mag_sq !== 33'd184557332) begin tests_failed++; $display("FAIL mag_hold: got %0b/%0d want 0/184557332", mag_valid, mag_sq); end
        tests_run++; if (mag_bin !== 2'd1 || mag_last !== 1'b1) begin tests_failed++; $display("FAIL mag_hold_side: got %0d/%0b want 1/1", mag_bin, mag_last); end
        tests_run++; if (peak_valid !== 1'b0) begin tests_failed++; $display("FAIL mag_pk_pulse: got %0b want 0", peak_valid); end
    endtask

    task automatic test_max_neg;
        cyc(1, 1, -32768, -32768);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        tests_run++; if (mag_valid !== 1'b1 || mag_sq !== 33'd2147483648) begin tests_failed++; $display("FAIL maxneg_sq: got %0b/%0d want 1/2147483648", mag_valid, mag_sq); end
        tests_run++; if (mag_sq[2*W] !== 1'b0) begin tests_failed++; $display("FAIL maxneg_msb: got %0b want 0", mag_sq[2*W]); end
        tests_run++; if (mag_bin !== 2'd0 || mag_last !== 1'b1 || frame_ovf !== 1'b0) begin tests_failed++; $display("FAIL maxneg_side: got %0d/%0b/%0b want 0/1/0", mag_bin, mag_last, frame_ovf); end
`ifdef FFT_PEAK_DETECT_EN
        tests_run++; if (peak_valid !== 1'b1 || peak_mag !== 33'd2147483648 || peak_bin !== 2'd0) begin tests_failed++; $display("FAIL single_bin_peak: got %0b/%0d/%0d want 1/2147483648/0", peak_valid, peak_mag, peak_bin); end
`endif
    endtask

    task automatic test_peak;
        int re [4] = '{1, 3, 0, 1};
        int im [4] = '{2, 0, -3, 1};
        int em [4] = '{5, 9, 9, 2};
        for (int i = 0; i < 4 + FFT_MAG_LAT; i++) begin
            if (i < 4) cyc(1, (i == 3), re[i], im[i]);
            else       cyc(0, 0, 0, 0);
            if (i >= FFT_MAG_LAT) begin
                int k;
                k = i - FFT_MAG_LAT;
                tests_run++; if (mag_valid !== 1'b1 || mag_sq !== 33'(em[k]) || mag_bin !== 2'(k)) begin tests_failed++; $display("FAIL peak_frame_bin%0d: got %0b/%0d/%0d want 1/%0d/%0d", k, mag_valid, mag_sq, mag_bin, em[k], k); end
`ifdef FFT_PEAK_DETECT_EN
                tests_run++; if (peak_valid !== (k == 3)) begin tests_failed++; $display("FAIL peak_valid_bin%0d: got %0b want %0b", k, peak_valid, (k == 3)); end
`endif
            end
        end
        tests_run++; if (mag_last !== 1'b1) begin tests_failed++; $display("FAIL peak_last: got %0b want 1", mag_last); end
`ifdef FFT_PEAK_DETECT_EN
        tests_run++; if (peak_mag !== 33'd9 || peak_bin !== 2'd1) begin tests_failed++; $display("FAIL peak_tie: got %0d/%0d want 9/1", peak_mag, peak_bin); end
        cyc(0, 0, 0, 0);
        tests_run++; if (peak_valid !== 1'b0 || peak_mag !== 33'd9 || peak_bin !== 2'd1) begin tests_failed++; $display("FAIL peak_hold: got %0b/%0d/%0d want 0/9/1", peak_valid, peak_mag, peak_bin); end
`endif
    endtask

    task automatic test_gaps;
        logic vp [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int   re [5] = '{7, 0, 0, 8, 6};
        int   eb [5] = '{0, 0, 0, 1, 2};
        for (int i = 0; i < 5 + FFT_MAG_LAT; i++) begin
            if (i < 5) cyc(vp[i], (i == 4), re[i], 0);
            else       cyc(0, 0, 0, 0);
            if (i >= FFT_MAG_LAT) begin
                int k;
                k = i - FFT_MAG_LAT;
                tests_run++; if (mag_valid !== vp[k]) begin tests_failed++; $display("FAIL gap_valid%0d: got %0b want %0b", k, mag_valid, vp[k]); end
                if (vp[k]) begin
                    tests_run++; if (mag_bin !== 2'(eb[k]) || mag_sq !== 33'(re[k] * re[k])) begin tests_failed++; $display("FAIL gap_bin%0d: got %0d/%0d want %0d/%0d", k, mag_bin, mag_sq, eb[k], re[k] * re[k]); end
                end
            end
        end
`ifdef FFT_PEAK_DETECT_EN
        tests_run++; if (peak_valid !== 1'b1 || peak_mag !== 33'd64 || peak_bin !== 2'd1) begin tests_failed++; $display("FAIL gap_peak: got %0b/%0d/%0d want 1/64/1", peak_valid, peak_mag, peak_bin); end
`endif
    endtask

    task automatic test_overflow;
        int re [5] = '{1, 2, 3, 0, 4};
        int im [5] = '{0, 0, 0, 2, 0};
        int em [5] = '{1, 4, 9, 4, 16};
        int eb [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5 + FFT_MAG_LAT; i++) begin
            if (i < 5) cyc(1, 0, re[i], im[i]);
            else       cyc(0, 0, 0, 0);
            if (i >= FFT_MAG_LAT) begin
                int k;
                k = i - FFT_MAG_LAT;
                tests_run++; if (mag_valid !== 1'b1 || mag_sq !== 33'(em[k]) || mag_bin !== 2'(eb[k])) begin tests_failed++; $display("FAIL ovf_bin%0d: got %0b/%0d/%0d want 1/%0d/%0d", k, mag_valid, mag_sq, mag_bin, em[k], eb[k]); end
                tests_run++; if (frame_ovf !== (k == 3) || mag_last !== 1'b0) begin tests_failed++; $display("FAIL ovf_pulse%0d: got %0b/%0b want %0b/0", k, frame_ovf, mag_last, (k == 3)); end
`ifdef FFT_PEAK_DETECT_EN
                tests_run++; if (peak_valid !== (k == 3)) begin tests_failed++; $display("FAIL ovf_pk_valid%0d: got %0b want %0b", k, peak_valid, (k == 3)); end
                if (k == 3) begin
                    tests_run++; if (peak_mag !== 33'd9 || peak_bin !== 2'd2) begin tests_failed++; $display("FAIL ovf_peak: got %0d/%0d want 9/2", peak_mag, peak_bin); end
                end
`else
                tests_run++; if (peak_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_pk_off%0d: got %0b want 0", k, peak_valid); end
`endif
            end
        end
    endtask

    task automatic test_reset_mid;
        cyc(1, 0, 5, 0);
        cyc(1, 0, 6, 0);
        @(negedge clk);
        tests_run++; if (mag_valid !== 1'b1 || mag_sq !== 33'd25 || mag_bin !== 2'd1) begin tests_failed++; $display("FAIL pre_rst: got %0b/%0d/%0d want 1/25/1", mag_valid, mag_sq, mag_bin); end
        reset_n = 1'b0;
        fft_valid = 1'b0;
        #1;
        tests_run++; if (mag_valid !== 1'b0 || mag_sq !== '0) begin tests_failed++; $display("FAIL midrst_mag: got %0b/%0d want 0/0", mag_valid, mag_sq); end
        tests_run++; if (mag_bin !== '0 || mag_last !== 1'b0 || frame_ovf !== 1'b0) begin tests_failed++; $display("FAIL midrst_side: got %0d/%0b/%0b want 0/0/0", mag_bin, mag_last, frame_ovf); end
        tests_run++; if (peak_valid !== 1'b0 || peak_mag !== '0 || peak_bin !== '0) begin tests_failed++; $display("FAIL midrst_peak: got %0b/%0d/%0d want 0/0/0", peak_valid, peak_mag, peak_bin); end
        @(negedge clk);
        reset_n = 1'b1;
        tests_run++; if (mag_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_inflight: got %0b want 0", mag_valid); end
        cyc(1, 1, 3, 4);
        cyc(0, 0, 0, 0);
        tests_run++; if (mag_valid !== 1'b0) begin tests_failed++; $display("FAIL postrst_early: got %0b want 0", mag_valid); end
        cyc(0, 0, 0, 0);
        tests_run++; if (mag_valid !== 1'b1 || mag_sq !== 33'd25 || mag_bin !== 2'd0) begin tests_failed++; $display("FAIL postrst_bin0: got %0b/%0d/%0d want 1/25/0", mag_valid, mag_sq, mag_bin); end
`ifdef FFT_PEAK_DETECT_EN
        tests_run++; if (peak_valid !== 1'b1 || peak_mag !== 33'd25 || peak_bin !== 2'd0) begin tests_failed++; $display("FAIL postrst_peak: got %0b/%0d/%0d want 1/25/0", peak_valid, peak_mag, peak_bin); end
`endif
    endtask

    initial begin
        test_reset();
        test_mag();
        test_max_neg();
        test_peak();
        test_gaps();
        test_overflow();
        test_reset_mid();
        cyc(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fft_mag_peak.md
FFT_MAG_PEAK -- requirements
Module: fft_mag_peak

Interface
REQ-001 SHALL have parameter W, default 16, meaning the signed width of each input component.
REQ-002 SHALL have parameter N_BINS, default 1024, meaning the maximum bins per frame (power of two, at least 4); BW = $clog2(N_BINS).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n, input, 1, meaning an asynchronous, active-low reset.
REQ-005 SHALL have port fft_valid, input, 1, meaning the input sample is valid this cycle.
REQ-006 SHALL have port fft_last, input, 1, meaning the last bin of the frame; it is qualified by fft_valid.
REQ-007 SHALL have port fft_real, input, W signed, meaning the real part.
REQ-008 SHALL have port fft_imag, input, W signed, meaning the imaginary part.
REQ-009 SHALL have port mag_sq, output, 2W+1 unsigned, meaning real^2 + imag^2.
REQ-010 SHALL have ports mag_valid, output, 1, and mag_last, output, 1, meaning a delayed fft_valid and a delayed fft_last.
REQ-011 SHALL have port mag_bin, output, BW, meaning the bin index of mag_sq within the frame.
REQ-012 SHALL have ports peak_valid, output, 1; peak_mag, output, 2W+1; and peak_bin, output, BW, meaning the per-frame maximum.
REQ-013 SHALL have port frame_ovf, output, 1, meaning a one-cycle pulse when N_BINS samples arrive without fft_last.

Function
REQ-014 SHALL compute mag_sq exactly, with no truncation or saturation; -2^(W-1) on both components yields 2^(2W-1).
REQ-015 SHALL have a fixed latency of 2 cycles: stage 1 registers both squares and stage 2 registers the sum, valid, last and bin.
REQ-016 SHALL run the pipeline freely with no backpressure; mag_valid is high exactly 2 cycles after each fft_valid, and gaps are preserved.
REQ-017 SHALL hold mag_sq, mag_last and mag_bin at their last values while mag_valid is low.
REQ-018 SHALL start the bin counter at 0, increment it on each fft_valid, and reset it to 0 after a valid fft_last.
REQ-019 SHALL, when the counter is N_BINS-1 and fft_last is low, wrap the counter to 0, pulse frame_ovf on the mag_valid cycle of that sample, and end the peak frame as if fft_last were high.
REQ-020 SHALL reset the running peak to the first bin of each frame; a later bin replaces it only if strictly greater, so ties keep the lowest bin.
REQ-021 SHALL, on the mag_valid cycle carrying mag_last or an overflow, pulse peak_valid for 1 cycle with the peak that includes that final bin.
REQ-022 SHALL hold peak_mag and peak_bin until the next peak_valid.
REQ-023 SHALL treat a frame of a single bin (fft_last on bin 0) as valid: peak_bin = 0 and peak_mag = mag_sq.

Reset
REQ-024 SHALL, on reset_n low, asynchronously clear all outputs, pipeline registers, the bin counter and the running peak to 0.
REQ-025 SHALL deassert reset_n synchronously to clk; a reset mid-frame discards the partial frame, in-flight samples produce no mag_valid, and the first post-reset sample is bin 0.

Configuration
REQ-026 SHALL, with macro FFT_PEAK_DETECT_EN defined, implement the peak tracking of REQ-020 to REQ-023.
REQ-027 SHALL, without FFT_PEAK_DETECT_EN, tie peak_valid, peak_mag and peak_bin to constant 0 and synthesise no peak registers; mag_* and frame_ovf are unchanged.

Structure
REQ-028 SHALL place in package fft_pkg: the mag_t typedef (function of W), the 2-cycle latency constant FFT_MAG_LAT, and a peak_t struct {mag, bin}.
REQ-029 SHALL implement the two-stage squaring datapath (valid and sideband pass-through) as sub-module fft_cmag_sq_stage; the top level holds the counter, peak logic and overflow logic.

Verification
REQ-030 SHALL cover: 23964+29636i at cycle t -> mag_sq = 1452565792 and mag_valid at t+2; -7964-11006i -> 184557332.
REQ-031 SHALL cover: -32768-32768i -> mag_sq = 2147483648, with no overflow and bit 2W = 0.
REQ-032 SHALL cover: a 4-bin frame of magnitudes 5, 9, 9, 2 with fft_last on bin 3 -> peak_valid with mag_last, peak_mag = 9, peak_bin = 1.
REQ-033 SHALL cover: a valid pattern of 1, 0, 0, 1, 1 -> mag_valid pattern of 1, 0, 0, 1, 1 delayed by 2 and mag_bin 0, 1, 2.
REQ-034 SHALL cover: N_BINS = 4 with 5 samples and no fft_last -> frame_ovf and peak_valid on bin 3, and the 5th sample has mag_bin = 0.
REQ-035 SHALL cover: reset_n low for 1 cycle mid-frame after 2 samples -> all outputs 0 at once, and the next sample has mag_bin = 0.
